// File: rtl/cpu_pkg.sv
// Shared definitions for the register-file writeback path.
// Holds the default bus widths and queue depth, plus the grant encoding.
// Also holds a saturating counter helper. Carries no logic of its own.
package cpu_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int DEPTH_DEF  = 2;
    localparam int CNT_W      = 16;

    // Identifies which requester received the most recent pop.
    typedef enum logic {
        GRANT_A = 1'b0,
        GRANT_B = 1'b1
    } grant_t;

    // Increments the counter, but holds it at the maximum value instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/rf_wr_fifo.sv
// Purpose: per-requester writeback queue, DEPTH entries, power-of-two wrap.
// Latency: an entry pushed at edge k is visible on head after edge k (0-cycle read of registered storage).
// Backpressure: full is from registered occupancy; push while full is ignored, pop while empty is ignored.
// Ports: clk/rst_n; push+din enqueue; pop dequeue; full/empty status; head = oldest entry.
module rf_wr_fifo
    import cpu_pkg::*;
#(
    parameter int W     = ADDR_W_DEF + DATA_W_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/rf_wr_arb.sv
// Purpose: round-robin merge of ALU (A) and load (B) writebacks onto one register-file write port.
// Latency: entry accepted into an empty, uncontested queue at edge k is written out at edge k+1.
// Backpressure: per-requester ready = !full of its queue (registered only); held writes wait in place.
// Ports: a_*/b_* valid-ready write requests; rf_we/rf_waddr/rf_wdata registered write port;
//        idle = nothing queued or issuing; conflict_cnt = saturating count of cycles with both queues occupied.
module rf_wr_arb
    import cpu_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_valid,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_ready,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              idle,
    output logic [CNT_W-1:0]  conflict_cnt
);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_ent_t;

    wr_ent_t a_head, b_head, sel;
    logic    a_full, a_empty, b_full, b_empty;
    logic    gnt_a, gnt_b;
    grant_t  last_grant, last_grant_nxt;

    assign a_ready = !a_full;
    assign b_ready = !b_full;

    rf_wr_fifo #(.W($bits(wr_ent_t)), .DEPTH(DEPTH)) u_fifo_a (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (a_valid && a_ready),
        .din   ({a_addr, a_data}),
        .pop   (gnt_a),
        .full  (a_full),
        .empty (a_empty),
        .head  (a_head)
    );

    rf_wr_fifo #(.W($bits(wr_ent_t)), .DEPTH(DEPTH)) u_fifo_b (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (b_valid && b_ready),
        .din   ({b_addr, b_data}),
        .pop   (gnt_b),
        .full  (b_full),
        .empty (b_empty),
        .head  (b_head)
    );

    // A wins when alone, or when both are waiting and B had the previous grant.
    always_comb begin
        gnt_a          = 1'b0;
        gnt_b          = 1'b0;
        last_grant_nxt = last_grant;
        if (!a_empty && (b_empty || last_grant == GRANT_B)) begin
            gnt_a          = 1'b1;
            last_grant_nxt = GRANT_A;
        end else if (!b_empty) begin
            gnt_b          = 1'b1;
            last_grant_nxt = GRANT_B;
        end
    end

    assign sel = gnt_a ? a_head : b_head;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant   <= GRANT_B;
            rf_we        <= 1'b0;
            rf_waddr     <= '0;
            rf_wdata     <= '0;
            conflict_cnt <= '0;
        end else begin
            last_grant <= last_grant_nxt;
            if (gnt_a || gnt_b) begin
                // R0 is hardwired zero: the entry is drained but never written.
                rf_we    <= (sel.addr != '0);
                rf_waddr <= sel.addr;
                rf_wdata <= sel.data;
            end else begin
                rf_we <= 1'b0;
            end
            if (!a_empty && !b_empty) conflict_cnt <= sat_inc(conflict_cnt);
        end
    end

    assign idle = a_empty && b_empty && !rf_we;

endmodule

// File: doc/rf_wr_arb.md
RF_WR_ARB -- requirements
Module: rf_wr_arb

Interface
REQ-001 Parameter DATA_W, default 32, SHALL set the register data width.
REQ-002 Parameter ADDR_W, default 5, SHALL set the register index width (32 registers).
REQ-003 Parameter DEPTH, default 2, SHALL set the per-requester queue depth (power of two, at least 2).
REQ-004 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-006 a_valid / a_addr / a_data  input  1 / ADDR_W / DATA_W  SHALL carry the requester A write (ALU writeback).
REQ-007 a_ready  output  1  SHALL indicate that queue A can accept.
REQ-008 b_valid / b_addr / b_data  input  1 / ADDR_W / DATA_W  SHALL carry the requester B write (load writeback).
REQ-009 b_ready  output  1  SHALL indicate that queue B can accept.
REQ-010 rf_we / rf_waddr / rf_wdata  output  1 / ADDR_W / DATA_W  SHALL drive the register-file write port.
REQ-011 idle  output  1  SHALL be high when both queues are empty and rf_we is low.
REQ-012 conflict_cnt  output  16  SHALL count cycles in which both queues are non-empty.

Function
REQ-013 A write SHALL be accepted on a rising edge where valid and ready are both high, and enqueued in its requester's FIFO.
REQ-014 ready SHALL be !full, derived from registered state only, with no combinational path from valid.
REQ-015 Each cycle with at least one non-empty queue, exactly one head entry SHALL be popped into the registered write-port outputs.
REQ-016 Arbitration SHALL be round-robin: with both queues non-empty, the requester not granted last SHALL win; with one queue non-empty, that queue SHALL win and last_grant SHALL update.
REQ-017 last_grant SHALL reset to B, so A wins the first contention.
REQ-018 Latency: an entry accepted into an empty, uncontested queue at edge k SHALL be popped at edge k+1, with rf_we high from edge k+1 to edge k+2.
REQ-019 Within one requester, writes SHALL reach the port in acceptance order; across requesters, order SHALL follow grant order.
REQ-020 A popped entry with address 0 SHALL be consumed with rf_we held low (R0 hardwired zero).
REQ-021 When nothing is popped, rf_we SHALL be low and rf_waddr/rf_wdata SHALL hold their previous values.
REQ-022 A push and a pop on the same queue in one cycle SHALL leave occupancy unchanged; pointers SHALL wrap modulo DEPTH.
REQ-023 conflict_cnt SHALL saturate at 16'hFFFF.

Reset
REQ-024 Asserting rst_n low SHALL immediately empty both queues, set rf_we=0, rf_waddr=0, rf_wdata=0, conflict_cnt=0, and last_grant=B.
REQ-025 During reset, a_ready and b_ready SHALL be high and idle SHALL be high.
REQ-026 Reset mid-operation SHALL discard all pending writes, and no write SHALL issue in the cycle after deassertion.

Structure
REQ-027 DATA_W, ADDR_W, DEPTH defaults and the grant encoding (GRANT_A, GRANT_B) SHALL reside in shared package cpu_pkg.
REQ-028 The per-requester queue SHALL be sub-module rf_wr_fifo (push, pop, full, empty, head), instantiated twice.

Verification
REQ-029 A-only: a_addr=3, a_data=32'h1234 accepted at edge 1 -> rf_we=1, rf_waddr=3, rf_wdata=32'h1234 between edges 2 and 3, idle=1 afterward.
REQ-030 Contention: A(5,10) and B(6,20) accepted on the same edge -> A written first, then B on the next cycle, conflict_cnt=1.
REQ-031 Full queue: three back-to-back A pushes with B holding the grant -> a_ready=0 after two entries; the third is held and accepted once a_ready returns.
REQ-032 R0: b_addr=0, b_data=32'hFFFF -> entry consumed, rf_we stays low, idle returns high.
REQ-033 Reset mid-stream: rst_n low with 2 entries queued in each FIFO -> all outputs at reset values immediately, and no rf_we pulse after deassertion.
